// File: rtl/nibble_serial_addsub.sv
// nibble_serial_addsub: serial adder/subtractor that works one 4-bit nibble
// per clock, LSB first. A request is taken in IDLE, NIBBLES cycles of RUN
// follow, and the result is held in DONE until the consumer takes it.
//
// Handshake rules: a transfer happens on a rising edge where valid && ready
// are both high. in_ready is high only in IDLE. out_valid is high only in
// DONE and stays high, with result/cout/ovf stable, until out_ready is high.
//
// Optional feature: define ADDSUB_ZERO_FLAG_EN to add the registered output
// 'zero', which is high in DONE when result == 0.
//
// fsm_state exposes the current state encoding for debug:
// 0 = IDLE, 1 = RUN, 2 = DONE.

module nibble_serial_addsub #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [4*NIBBLES-1:0]   a,
    input  logic [4*NIBBLES-1:0]   b,
    input  logic                   sub,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [4*NIBBLES-1:0]   result,
    output logic                   cout,
    output logic                   ovf,
`ifdef ADDSUB_ZERO_FLAG_EN
    output logic                   zero,
`endif
    output logic                   busy,
    output logic [1:0]             fsm_state
);

    localparam int W  = 4 * NIBBLES;
    // The nibble index needs at least one bit, even for a single nibble.
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;

    // Captured operands, so input changes after acceptance have no effect.
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic            sub_q;

    // Serial datapath state.
    logic [IW-1:0]   idx;
    logic            carry;
    logic [W-1:0]    res_q;
    logic            cout_q;
    logic            ovf_q;

    // Per-nibble combinational arithmetic.
    logic [3:0]      nib_a;
    logic [3:0]      nib_b;
    logic [4:0]      nib_sum;
    logic [3:0]      low_sum;
    logic            top_bit_cin;
    logic            last_nib;
    logic            accept;
    logic [W-1:0]    res_next;

    assign accept   = (state == S_IDLE) && in_valid;
    assign last_nib = (idx == IW'(NIBBLES - 1));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: IDLE -> RUN on accept, RUN -> DONE after the top
    // nibble, DONE -> IDLE when the consumer takes the result.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (in_valid)  state_next = S_RUN;
            S_RUN:  if (last_nib)  state_next = S_DONE;
            S_DONE: if (out_ready) state_next = S_IDLE;
            default:               state_next = S_IDLE;
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        in_ready  = 1'b0;
        busy      = 1'b0;
        out_valid = 1'b0;
        case (state)
            S_IDLE:  in_ready  = 1'b1;
            S_RUN:   busy      = 1'b1;
            S_DONE:  out_valid = 1'b1;
            default: in_ready  = 1'b0;
        endcase
        fsm_state = state;
    end

    // One nibble of add/subtract. Subtraction inverts B and uses the
    // captured sub as the initial carry-in (two's complement). low_sum
    // yields the carry into bit 3 of the nibble, which for the top nibble
    // is the carry into the sign bit.
    always_comb begin
        nib_a       = a_q[{idx, 2'b00} +: 4];
        nib_b       = b_q[{idx, 2'b00} +: 4] ^ {4{sub_q}};
        nib_sum     = {1'b0, nib_a} + {1'b0, nib_b} + {4'b0000, carry};
        low_sum     = {1'b0, nib_a[2:0]} + {1'b0, nib_b[2:0]} + {3'b000, carry};
        top_bit_cin = low_sum[3];
        res_next    = res_q;
        res_next[{idx, 2'b00} +: 4] = nib_sum[3:0];
    end

    // Operand capture on the accept edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            sub_q <= 1'b0;
        end else if (accept) begin
            a_q   <= a;
            b_q   <= b;
            sub_q <= sub;
        end
    end

    // Nibble index and running carry: seeded on accept, advanced in RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx   <= '0;
            carry <= 1'b0;
        end else if (accept) begin
            idx   <= '0;
            carry <= sub;
        end else if (state == S_RUN) begin
            idx   <= last_nib ? '0 : idx + IW'(1);
            carry <= nib_sum[4];
        end
    end

    // Result nibble write-back, and flags captured with the top nibble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (state == S_RUN) begin
            res_q <= res_next;
            if (last_nib) begin
                cout_q <= nib_sum[4];
                ovf_q  <= top_bit_cin ^ nib_sum[4];
            end
        end
    end

`ifdef ADDSUB_ZERO_FLAG_EN
    logic zero_q;

    // Zero flag, registered on the same edge that completes the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_q <= 1'b0;
        end else if ((state == S_RUN) && last_nib) begin
            zero_q <= (res_next == '0);
        end
    end

    assign zero = zero_q;
`endif

    assign result = res_q;
    assign cout   = cout_q;
    assign ovf    = ovf_q;

endmodule

// File: doc/nibble_serial_addsub.md
NIBBLE_SERIAL_ADDSUB -- requirements
Module: nibble_serial_addsub

Interface
REQ-001 SHALL have parameter: NIBBLES, 4, number of 4-bit nibbles per operand; operand width W = 4*NIBBLES; legal range 1..8.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port: in_valid  input  1  operand request valid.
REQ-005 SHALL have port: in_ready  output  1  block can accept an operand request.
REQ-006 SHALL have port: a  input  W  operand A.
REQ-007 SHALL have port: b  input  W  operand B.
REQ-008 SHALL have port: sub  input  1  0 = A+B; 1 = A-B.
REQ-009 SHALL have port: out_valid  output  1  result valid.
REQ-010 SHALL have port: out_ready  input  1  consumer accepts the result.
REQ-011 SHALL have port: result  output  W  sum or difference, modulo 2^W.
REQ-012 SHALL have port: cout  output  1  carry out of the top nibble; for subtract, 1 = no borrow.
REQ-013 SHALL have port: ovf  output  1  two's-complement signed overflow.
REQ-014 SHALL have port: busy  output  1  high in RUN state.

Function
REQ-015 SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-016 SHALL drive in_ready high only in IDLE, and busy high only in RUN.
REQ-017 SHALL accept a request on the edge where in_valid && in_ready: register a, b and sub, clear the nibble index to 0, and move to RUN.
REQ-018 SHALL ignore in_valid outside IDLE; operand changes after acceptance SHALL have no effect.
REQ-019 SHALL, in RUN, process one nibble per cycle from LSB to MSB: nibble i = A[i] + (B[i] XOR {4{sub}}) + carry.
REQ-020 SHALL set the carry-in for nibble 0 to the captured sub; for each later nibble, the carry-in SHALL be the previous nibble's carry-out.
REQ-021 SHALL write each nibble's sum into the result register at position i on the edge that completes nibble i.
REQ-022 SHALL move to DONE on the edge that completes nibble NIBBLES-1; out_valid SHALL rise exactly NIBBLES cycles after the accept edge.
REQ-023 SHALL, on that same edge, register cout as the top-nibble carry-out and ovf as (carry into bit W-1) XOR (carry out of bit W-1).
REQ-024 SHALL, in DONE, hold out_valid, result, cout and ovf stable until out_ready is high, then return to IDLE on that edge with out_valid low.
REQ-025 SHALL make the earliest next accept one cycle after the output handshake; the minimum period between requests is NIBBLES+2 cycles.
REQ-026 SHALL, when NIBBLES=1, perform RUN for one cycle only, with no special case.

Reset
REQ-027 SHALL, while rst_n is low, force state IDLE, nibble index 0, result 0, cout 0, ovf 0, out_valid 0, busy 0 and in_ready 1.
REQ-028 SHALL, if reset asserts during RUN or DONE, discard the operation with no output handshake; the first request after deassertion SHALL compute correctly.

Configuration
REQ-029 SHALL, when macro ADDSUB_ZERO_FLAG_EN is defined, add output port zero (1 bit), registered with the result, reset to 0, and high in DONE iff result == 0.
REQ-030 SHALL, without ADDSUB_ZERO_FLAG_EN, have no zero port and no zero-detect logic; all other behaviour SHALL be identical.

Verification (NIBBLES=4)
REQ-031 SHALL test add: 0x1234 + 0x0FFF -> result 0x2233, cout 0, ovf 0, out_valid 4 cycles after accept.
REQ-032 SHALL test subtract: 0x0005 - 0x0007 -> result 0xFFFE, cout 0, ovf 0; 0x0007 - 0x0005 -> result 0x0002, cout 1.
REQ-033 SHALL test overflow: 0x7FFF + 0x0001 -> result 0x8000, ovf 1, cout 0; 0x8000 - 0x0001 -> result 0x7FFF, ovf 1, cout 1.
REQ-034 SHALL test backpressure: out_ready low for 3 cycles in DONE -> outputs stable, in_ready 0, a concurrent in_valid ignored; then out_ready high -> IDLE, in_ready 1 on the next cycle.
REQ-035 SHALL test reset mid-RUN: pulse rst_n low after 2 nibbles -> out_valid 0 and in_ready 1 immediately; a following 0xFFFF + 0x0001 -> result 0x0000, cout 1, ovf 0, and zero 1 if ADDSUB_ZERO_FLAG_EN is defined.
